avst_pkt_rx: RTL and testbench

AVST_PKT_RX -- requirements
Module: avst_pkt_rx

---
 rtl/avst_pkt_pkg.sv | 29 ++
 rtl/avst_pkt_if.sv | 19 +
 rtl/avst_pkt_len_acc.sv | 50 +++++
 rtl/avst_pkt_rx.sv | 155 +++++++++++++++
 tb/tb_avst_pkt_rx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/avst_pkt_pkg.sv
// Shared types and helpers for the Avalon-ST packet receiver.
//   state_e     : receiver FSM states (IDLE, IN_PKT, DROP)
//   LEN_W       : reported packet length width (saturating)
//   BEAT_W      : width of a per-beat byte count
//   PKT_CNT_W   : good-packet counter width (statistics build)
//   BYTE_CNT_W  : good-byte counter width (statistics build)
//   beat_bytes(): bytes carried by one beat given bus width, eop and empty
package avst_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DROP
  } state_e;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned BEAT_W     = 17;
  localparam int unsigned PKT_CNT_W  = 32;
  localparam int unsigned BYTE_CNT_W = 48;

  function automatic logic [BEAT_W-1:0] beat_bytes(input int unsigned width,
                                                   input logic        eop,
                                                   input logic [BEAT_W-1:0] empty);
    logic [BEAT_W-1:0] full;
    full = BEAT_W'(width / 8);
    return eop ? (full - empty) : full;
  endfunction

endpackage

// File: rtl/avst_pkt_if.sv
// Avalon-ST bus bundle.
//   valid, sop, eop, error, empty, data : source -> sink
//   ready                               : sink -> source (ready latency 0)
interface avalonST #(
  parameter int unsigned WIDTH = 512
);
  localparam int unsigned EMPTY_W = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1;

  logic               valid;
  logic               sop;
  logic               eop;
  logic               error;
  logic [EMPTY_W-1:0] empty;
  logic [WIDTH-1:0]   data;
  logic               ready;

  modport sink   (input valid, sop, eop, error, empty, data, output ready);
  modport source (output valid, sop, eop, error, empty, data, input ready);
endinterface

// File: rtl/avst_pkt_len_acc.sv
// Saturating packet length accumulator with sticky error and MAX_LEN check.
//   clk, rst   : clock, asynchronous active-high reset
//   beat_i     : commit this beat into the accumulator
//   restart_i  : this beat starts a new packet (base length/error = 0)
//   err_i      : error flag carried by this beat
//   bytes_i    : byte count of this beat
//   len_o      : accumulated length of the open packet (before this beat)
//   sum_len_o  : saturated length including this beat
//   sum_err_o  : sticky error including this beat and the oversize check
module avst_pkt_len_acc
  import avst_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN = 9600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_i,
  input  logic              restart_i,
  input  logic              err_i,
  input  logic [BEAT_W-1:0] bytes_i,
  output logic [LEN_W-1:0]  len_o,
  output logic [LEN_W-1:0]  sum_len_o,
  output logic              sum_err_o
);

  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic [17:0]      sum;

  // Two spare bits hold a saturated 16-bit base plus a full 17-bit beat, so
  // the oversize compare still sees the true length beyond 16'hFFFF.
  always_comb begin
    sum       = (restart_i ? 18'd0 : {2'b00, len_q}) + {1'b0, bytes_i};
    sum_len_o = (sum > 18'h0FFFF) ? '1 : sum[LEN_W-1:0];
    sum_err_o = (restart_i ? 1'b0 : err_q) | err_i | (sum > 18'(MAX_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      err_q <= 1'b0;
    end else if (beat_i) begin
      len_q <= sum_len_o;
      err_q <= sum_err_o;
    end
  end

  assign len_o = len_q;

endmodule

// File: rtl/avst_pkt_rx.sv
// Avalon-ST packet receiver: measures packets, flags bad and mis-framed ones.
//   clk, rst    : clock, asynchronous active-high reset
//   snk         : Avalon-ST sink (ready = rx_en while out of reset)
//   rx_en       : acceptance enable / backpressure
//   pkt_done    : one-cycle strobe per completed or aborted packet
//   pkt_len     : byte length of the reported packet (saturating)
//   pkt_err     : reported packet is bad (error, oversize, truncated)
//   framing_err : one-cycle strobe on a sop/eop violation
//   pkt_count   : good packets       (only with AVST_PKT_RX_STATS_EN)
//   byte_count  : bytes in good pkts (only with AVST_PKT_RX_STATS_EN)
module avst_pkt_rx
  import avst_pkt_pkg::*;
#(
  parameter int unsigned WIDTH   = 512,
  parameter int unsigned MAX_LEN = 9600
) (
  input  logic             clk,
  input  logic             rst,
  avalonST.sink            snk,
  input  logic             rx_en,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_err,
  output logic             framing_err
`ifdef AVST_PKT_RX_STATS_EN
  ,
  output logic [PKT_CNT_W-1:0]  pkt_count,
  output logic [BYTE_CNT_W-1:0] byte_count
`endif
);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;

  logic              accept;
  logic              acc_beat, acc_restart;
  logic [BEAT_W-1:0] bytes;
  logic [LEN_W-1:0]  acc_len, sum_len;
  logic              sum_err;

  assign snk.ready = rx_en & ~rst;
  assign accept    = snk.valid & snk.ready;
  assign bytes     = beat_bytes(WIDTH, snk.eop, BEAT_W'(snk.empty));

  avst_pkt_len_acc #(
    .MAX_LEN(MAX_LEN)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .beat_i   (acc_beat),
    .restart_i(acc_restart),
    .err_i    (snk.error),
    .bytes_i  (bytes),
    .len_o    (acc_len),
    .sum_len_o(sum_len),
    .sum_err_o(sum_err)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    len_d       = len_q;
    perr_d      = perr_q;
    ferr_d      = 1'b0;
    acc_beat    = 1'b0;
    acc_restart = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE, DROP: begin
          // A sop while dropping opens a fresh packet just as it would in IDLE;
          // the framing error was already flagged when the drop began.
          if (snk.sop) begin
            acc_beat    = 1'b1;
            acc_restart = 1'b1;
            if (snk.eop) begin
              done_d  = 1'b1;
              len_d   = sum_len;
              perr_d  = sum_err;
              state_d = IDLE;
            end else begin
              state_d = IN_PKT;
            end
          end else if (state_q == IDLE) begin
            ferr_d  = 1'b1;
            state_d = snk.eop ? IDLE : DROP;
          end else if (snk.eop) begin
            state_d = IDLE;
          end
        end
        IN_PKT: begin
          acc_beat = 1'b1;
          if (snk.sop) begin
            // Truncated packet: report what was collected, restart on this beat.
            ferr_d      = 1'b1;
            done_d      = 1'b1;
            len_d       = acc_len;
            perr_d      = 1'b1;
            acc_restart = 1'b1;
            state_d     = snk.eop ? IDLE : IN_PKT;
          end else if (snk.eop) begin
            done_d  = 1'b1;
            len_d   = sum_len;
            perr_d  = sum_err;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      len_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      len_q   <= len_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign pkt_done    = done_q;
  assign pkt_len     = len_q;
  assign pkt_err     = perr_q;
  assign framing_err = ferr_q;

`ifdef AVST_PKT_RX_STATS_EN
  logic [PKT_CNT_W-1:0]  pkt_cnt_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;

  // Counters step together with the report they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (done_d && !perr_d) begin
      pkt_cnt_q  <= pkt_cnt_q + 1'b1;
      byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(len_d);
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_avst_pkt_rx.sv
// Bench for avst_pkt_rx: two instances (MAX_LEN 9600 and 128) share one
// stimulus stream; a packet-level model predicts every output each cycle.
// Counter ports are checked when AVST_PKT_RX_STATS_EN is defined.
module tb_avst_pkt_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b1;
  logic        valid = 1'b0, sop = 1'b0, eop = 1'b0, error = 1'b0;
  logic [5:0]  empty = '0;
  logic [511:0] data = '0;

  logic        done_a, err_a, ferr_a, done_b, err_b, ferr_b;
  logic [15:0] len_a, len_b;
`ifdef AVST_PKT_RX_STATS_EN
  logic [31:0] pc_a, pc_b;
  logic [47:0] bc_a, bc_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalonST #(.WIDTH(512)) if_a ();
  avalonST #(.WIDTH(512)) if_b ();
  assign if_a.valid = valid; assign if_a.sop = sop; assign if_a.eop = eop;
  assign if_a.error = error; assign if_a.empty = empty; assign if_a.data = data;
  assign if_b.valid = valid; assign if_b.sop = sop; assign if_b.eop = eop;
  assign if_b.error = error; assign if_b.empty = empty; assign if_b.data = data;

  avst_pkt_rx #(.WIDTH(512), .MAX_LEN(9600)) dut_a (
    .clk(clk), .rst(rst), .snk(if_a.sink), .rx_en(rx_en),
    .pkt_done(done_a), .pkt_len(len_a), .pkt_err(err_a), .framing_err(ferr_a)
`ifdef AVST_PKT_RX_STATS_EN
    , .pkt_count(pc_a), .byte_count(bc_a)
`endif
  );

  avst_pkt_rx #(.WIDTH(512), .MAX_LEN(128)) dut_b (
    .clk(clk), .rst(rst), .snk(if_b.sink), .rx_en(rx_en),
    .pkt_done(done_b), .pkt_len(len_b), .pkt_err(err_b), .framing_err(ferr_b)
`ifdef AVST_PKT_RX_STATS_EN
    , .pkt_count(pc_b), .byte_count(bc_b)
`endif
  );

  task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  int          m_len = 0;
  bit          m_open = 0, m_drop = 0, m_err = 0;
  bit          e_done = 0, e_ferr = 0, e_err_a = 0, e_err_b = 0;
  int          e_len = 0;
  logic [31:0] e_pc_a = '0, e_pc_b = '0;
  logic [47:0] e_bc_a = '0, e_bc_b = '0;

  task automatic report(input int l, input bit bad_a, input bit bad_b);
    int s;
    s = (l > 65535) ? 65535 : l;
    e_done = 1; e_len = s; e_err_a = bad_a; e_err_b = bad_b;
    if (!bad_a) begin e_pc_a = e_pc_a + 1; e_bc_a = e_bc_a + 48'(s); end
    if (!bad_b) begin e_pc_b = e_pc_b + 1; e_bc_b = e_bc_b + 48'(s); end
  endtask

  always @(negedge clk) begin
    int  bytes;
    bit  was_open;
    if (rst) begin
      chk("rst_ready_a", if_a.ready, 0); chk("rst_ready_b", if_b.ready, 0);
      chk("rst_done_a", done_a, 0); chk("rst_len_a", len_a, 0);
      chk("rst_err_a", err_a, 0); chk("rst_ferr_a", ferr_a, 0);
      chk("rst_done_b", done_b, 0); chk("rst_len_b", len_b, 0);
      chk("rst_err_b", err_b, 0); chk("rst_ferr_b", ferr_b, 0);
      m_len = 0; m_open = 0; m_drop = 0; m_err = 0;
      e_done = 0; e_ferr = 0; e_len = 0; e_err_a = 0; e_err_b = 0;
      e_pc_a = '0; e_pc_b = '0; e_bc_a = '0; e_bc_b = '0;
    end else begin
      chk("ready_a", if_a.ready, rx_en); chk("ready_b", if_b.ready, rx_en);
      chk("done_a", done_a, e_done); chk("len_a", len_a, e_len);
      chk("err_a", err_a, e_err_a); chk("ferr_a", ferr_a, e_ferr);
      chk("done_b", done_b, e_done); chk("len_b", len_b, e_len);
      chk("err_b", err_b, e_err_b); chk("ferr_b", ferr_b, e_ferr);
`ifdef AVST_PKT_RX_STATS_EN
      chk("pkt_count_a", pc_a, e_pc_a); chk("byte_count_a", bc_a, e_bc_a);
      chk("pkt_count_b", pc_b, e_pc_b); chk("byte_count_b", bc_b, e_bc_b);
`endif
      e_done = 0; e_ferr = 0;
      if (valid && rx_en) begin
        bytes = eop ? 64 - int'(empty) : 64;
        if (sop) begin
          was_open = m_open;
          if (m_open) begin e_ferr = 1; report(m_len, 1, 1); end
          m_len = bytes; m_err = error; m_drop = 0;
          if (eop) begin
            m_open = 0;
            if (!was_open) report(m_len, m_err || m_len > 9600, m_err || m_len > 128);
          end else m_open = 1;
        end else if (m_open) begin
          m_len += bytes; m_err |= error;
          if (eop) begin
            m_open = 0;
            report(m_len, m_err || m_len > 9600, m_err || m_len > 128);
          end
        end else if (m_drop) begin
          if (eop) m_drop = 0;
        end else begin
          e_ferr = 1; m_drop = !eop;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input bit s, input bit e, input int emp, input bit er);
    @(posedge clk); #1;
    valid = 1; sop = s; eop = e; empty = 6'(emp); error = er;
    data = {16{$urandom}};
  endtask

  // Ends the current beat; on return the last beat's report is visible.
  task automatic gap();
    @(posedge clk); #1;
    valid = 0; sop = 0; eop = 0; error = 0; empty = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_ready", if_a.ready, 0);
    chk("lit_rst_len", len_a, 0);
    rst = 0;

    // 3-beat packet, empty=4 on eop -> 188 bytes (oversize for MAX_LEN=128)
    beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 1, 4, 0); gap();
    chk("lit_3beat_done", done_a, 1); chk("lit_3beat_len", len_a, 188);
    chk("lit_3beat_err", err_a, 0);   chk("lit_3beat_ferr", ferr_a, 0);
    chk("lit_3beat_err_b", err_b, 1);

    // Single-beat packet, empty=63 -> 1 byte
    beat(1, 1, 63, 0); gap();
    chk("lit_1byte_len", len_a, 1); chk("lit_1byte_err", err_a, 0);

    // Beat without sop, eop two beats later, then good 1-beat packet
    beat(0, 0, 0, 0); gap();
    chk("lit_drop_ferr", ferr_a, 1); chk("lit_drop_done", done_a, 0);
    beat(0, 0, 0, 0); beat(0, 1, 10, 0); gap();
    chk("lit_drop_end_ferr", ferr_a, 0); chk("lit_drop_end_done", done_a, 0);
    beat(1, 1, 0, 0); gap();
    chk("lit_after_drop_len", len_a, 64); chk("lit_after_drop_done", done_a, 1);

    // Second sop at beat 3 of an open packet
    beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(1, 0, 0, 0); gap();
    chk("lit_resop_ferr", ferr_a, 1); chk("lit_resop_len", len_a, 128);
    chk("lit_resop_err", err_a, 1);
    beat(0, 0, 0, 0); beat(0, 1, 0, 0); gap();
    chk("lit_resop_new_len", len_a, 192); chk("lit_resop_new_err", err_a, 0);

    // Error flag on a middle beat is sticky
    beat(1, 0, 0, 0); beat(0, 0, 0, 1); beat(0, 1, 8, 0); gap();
    chk("lit_sticky_err", err_a, 1); chk("lit_sticky_len", len_a, 184);

    // sop+eop inside an open packet, then a clean packet
    beat(1, 0, 0, 0); beat(1, 1, 0, 0); gap();
    beat(1, 1, 32, 0); gap();
    chk("lit_sopeop_len", len_a, 32);

    // sop while dropping opens a new packet
    beat(0, 0, 0, 0); beat(1, 0, 0, 0); beat(0, 1, 0, 0); gap();
    chk("lit_drop_sop_len", len_a, 128); chk("lit_drop_sop_err", err_a, 0);

    // rx_en toggles every cycle with valid held high
    begin
      int i = 0;
      rx_en = 0;
      forever begin
        @(posedge clk); #1;
        if (valid && rx_en) i++;
        if (i == 3) break;
        rx_en = !rx_en;
        valid = 1; sop = (i == 0); eop = (i == 2); empty = '0; error = 0;
      end
      valid = 0; sop = 0; eop = 0; rx_en = 1;
      #1;
      chk("lit_bp_len", len_a, 192); chk("lit_bp_err_a", err_a, 0);
      chk("lit_bp_err_b", err_b, 1);
    end

    // Length boundary at MAX_LEN, and saturation past 16'hFFFF
    beat(1, 0, 0, 0);
    for (int i = 0; i < 148; i++) beat(0, 0, 0, 0);
    beat(0, 1, 0, 0); gap();
    chk("lit_maxlen_len", len_a, 9600); chk("lit_maxlen_err", err_a, 0);
    beat(1, 0, 0, 0);
    for (int i = 0; i < 1028; i++) beat(0, 0, 0, 0);
    beat(0, 1, 0, 0); gap();
    chk("lit_sat_len", len_a, 16'hFFFF); chk("lit_sat_err", err_a, 1);

    // Statistics: 2 good + 1 errored after a fresh reset
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    beat(1, 1, 0, 0); beat(1, 0, 0, 0); beat(0, 1, 28, 0); beat(1, 1, 0, 1); gap();
    chk("lit_bad_err", err_a, 1);
`ifdef AVST_PKT_RX_STATS_EN
    chk("lit_pkt_count", pc_a, 2); chk("lit_byte_count", bc_a, 164);
`endif

    // Reset in the middle of a packet
    beat(1, 0, 0, 0); beat(0, 0, 0, 0);
    @(posedge clk); #1 rst = 1; valid = 0; sop = 0;
    #1;
    chk("lit_midrst_len", len_a, 0); chk("lit_midrst_done", done_a, 0);
`ifdef AVST_PKT_RX_STATS_EN
    chk("lit_midrst_pc", pc_a, 0); chk("lit_midrst_bc", bc_a, 0);
`endif
    @(posedge clk); #1 rst = 0;
    beat(0, 1, 0, 0); beat(1, 1, 0, 0); gap();
    chk("lit_post_rst_len", len_a, 64);

    repeat (3) gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
